// File: rtl/dsp48a1.sv
// DSP48A1-style arithmetic slice: D +/- B pre-adder, 18x18 unsigned multiplier and a
// 48-bit post-adder/subtractor. Each pipeline stage is a register or a wire by parameter.

// One optional pipeline stage: clears asynchronously, loads on CE, or collapses to a wire.
module dsp48a1_stage #(
  parameter int unsigned W  = 18,
  parameter bit          EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  if (EN) begin : g_reg
    logic [W-1:0] data_q, data_d;

    always_comb data_d = ce ? din : data_q;

    // NOTE: state is written only with <= so every flop samples pre-edge values;
    // the clear is in the sensitivity list, so it acts without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
    end

    assign dout = data_q;
  end else begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, ce};
    assign dout        = din;
  end
endmodule

module dsp48a1 #(
  parameter int unsigned A0REG       = 0,
  parameter int unsigned A1REG       = 1,
  parameter int unsigned B0REG       = 0,
  parameter int unsigned B1REG       = 1,
  parameter int unsigned CREG        = 1,
  parameter int unsigned DREG        = 1,
  parameter int unsigned MREG        = 1,
  parameter int unsigned PREG        = 1,
  parameter int unsigned CARRYINREG  = 1,
  parameter int unsigned CARRYOUTREG = 1,
  parameter int unsigned OPMODEREG   = 1,
  parameter int unsigned CARRYINSEL  = 0,
  parameter string       B_INPUT     = "DIRECT"
) (
  input  logic        CLK,
  input  logic        RSTA,
  input  logic        RSTB,
  input  logic        RSTC,
  input  logic        RSTD,
  input  logic        RSTM,
  input  logic        RSTP,
  input  logic        RSTCARRYIN,
  input  logic        RSTOPMODE,
  input  logic        CEA,
  input  logic        CEB,
  input  logic        CEC,
  input  logic        CED,
  input  logic        CEM,
  input  logic        CEP,
  input  logic        CECARRYIN,
  input  logic        CEOPMODE,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] D,
  input  logic [17:0] BCIN,
  input  logic [47:0] C,
  input  logic [47:0] PCIN,
  input  logic        CARRYIN,
  input  logic [7:0]  OPMODE,
  output logic [17:0] BCOUT,
  output logic [35:0] M,
  output logic [47:0] P,
  output logic [47:0] PCOUT,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);
  localparam bit USE_BCIN = (B_INPUT == "CASCADE");

  logic [17:0] b_src, a0, a1, b0, d_s, pre_sum, b1;
  logic [35:0] mult, m_s;
  logic [47:0] c_s, p_s, x_mux, z_mux;
  logic [48:0] post;
  logic [7:0]  op;
  logic        ci_src, cin, co_s;

  assign b_src  = USE_BCIN ? BCIN : B;
  assign ci_src = (CARRYINSEL != 0) ? op[5] : CARRYIN;

  dsp48a1_stage #(.W(18), .EN(A0REG != 0)) u_a0 (.clk(CLK), .rst_n(RSTA), .ce(CEA), .din(A),     .dout(a0));
  dsp48a1_stage #(.W(18), .EN(A1REG != 0)) u_a1 (.clk(CLK), .rst_n(RSTA), .ce(CEA), .din(a0),    .dout(a1));
  dsp48a1_stage #(.W(18), .EN(B0REG != 0)) u_b0 (.clk(CLK), .rst_n(RSTB), .ce(CEB), .din(b_src), .dout(b0));
  dsp48a1_stage #(.W(18), .EN(DREG  != 0)) u_d  (.clk(CLK), .rst_n(RSTD), .ce(CED), .din(D),     .dout(d_s));
  dsp48a1_stage #(.W(48), .EN(CREG  != 0)) u_c  (.clk(CLK), .rst_n(RSTC), .ce(CEC), .din(C),     .dout(c_s));
  dsp48a1_stage #(.W(8),  .EN(OPMODEREG != 0)) u_op (
    .clk(CLK), .rst_n(RSTOPMODE), .ce(CEOPMODE), .din(OPMODE), .dout(op)
  );
  dsp48a1_stage #(.W(18), .EN(B1REG != 0)) u_b1 (.clk(CLK), .rst_n(RSTB), .ce(CEB), .din(pre_sum), .dout(b1));
  dsp48a1_stage #(.W(36), .EN(MREG  != 0)) u_m  (.clk(CLK), .rst_n(RSTM), .ce(CEM), .din(mult),    .dout(m_s));
  dsp48a1_stage #(.W(1),  .EN(CARRYINREG != 0)) u_ci (
    .clk(CLK), .rst_n(RSTCARRYIN), .ce(CECARRYIN), .din(ci_src), .dout(cin)
  );
  dsp48a1_stage #(.W(48), .EN(PREG != 0)) u_p (.clk(CLK), .rst_n(RSTP), .ce(CEP), .din(post[47:0]), .dout(p_s));
  dsp48a1_stage #(.W(1),  .EN(CARRYOUTREG != 0)) u_co (
    .clk(CLK), .rst_n(RSTP), .ce(CEP), .din(post[48]), .dout(co_s)
  );

  // Pre-adder and multiplier: both operate modulo their result width.
  always_comb begin
    // NOTE: each variable gets a default before any branch, so no path can infer a latch.
    pre_sum = b0;
    if (op[4]) pre_sum = op[6] ? (d_s - b0) : (d_s + b0);
    mult = {18'd0, a1} * {18'd0, b1};
  end

  // Operand muxes and post-adder; P feedback assumes PREG=1 so it is the registered result.
  always_comb begin
    x_mux = '0;
    z_mux = '0;
    case (op[1:0])
      2'd1:    x_mux = {12'd0, m_s};
      2'd2:    x_mux = p_s;
      2'd3:    x_mux = {d_s[11:0], a1, b1};
      default: x_mux = '0;
    endcase
    case (op[3:2])
      2'd1:    z_mux = PCIN;
      2'd2:    z_mux = p_s;
      2'd3:    z_mux = c_s;
      default: z_mux = '0;
    endcase
    // Subtract mode: bit 48 of the 49-bit difference is the borrow.
    if (op[7]) post = {1'b0, z_mux} - ({1'b0, x_mux} + {48'd0, cin});
    else       post = {1'b0, z_mux} + {1'b0, x_mux} + {48'd0, cin};
  end

  assign BCOUT     = b1;
  assign M         = m_s;
  assign P         = p_s;
  assign PCOUT     = p_s;
  assign CARRYOUT  = co_s;
  assign CARRYOUTF = co_s;
endmodule

// File: tb/tb_dsp48a1.sv
// Directed and randomized checks of dsp48a1 (default parameters) against a
// cycle-indexed latency model built from the slice's arithmetic rules.
module tb_dsp48a1;
  localparam int NRAND = 200;
  localparam int OFF   = 2;
  localparam longint unsigned MASK48 = 64'hFFFF_FFFF_FFFF;
  localparam longint unsigned MOD18  = 64'h40000;

  logic        CLK = 1'b0;
  logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
  logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
  logic [17:0] A, B, D, BCIN;
  logic [47:0] C, PCIN;
  logic        CARRYIN;
  logic [7:0]  OPMODE;
  logic [17:0] BCOUT;
  logic [35:0] M;
  logic [47:0] P, PCOUT;
  logic        CARRYOUT, CARRYOUTF;

  int errors = 0;
  int checks = 0;

  // Input history (index = clock edge + OFF) and model outputs per edge.
  longint unsigned a_h[NRAND+OFF], b_h[NRAND+OFF], d_h[NRAND+OFF], c_h[NRAND+OFF];
  longint unsigned pcin_h[NRAND+OFF], ci_h[NRAND+OFF];
  logic [7:0]      op_h[NRAND+OFF];
  longint unsigned b1_m[NRAND+OFF], m_m[NRAND+OFF], p_m[NRAND+OFF], co_m[NRAND+OFF];

  always #5 CLK = ~CLK;

  dsp48a1 dut (
    .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM),
    .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
    .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .A(A), .B(B), .D(D), .BCIN(BCIN), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
    .OPMODE(OPMODE), .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT),
    .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic set_rst(input logic v);
    RSTA = v; RSTB = v; RSTC = v; RSTD = v; RSTM = v; RSTP = v; RSTCARRYIN = v; RSTOPMODE = v;
  endtask

  task automatic set_ce(input logic v);
    CEA = v; CEB = v; CEC = v; CED = v; CEM = v; CEP = v; CECARRYIN = v; CEOPMODE = v;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic longint unsigned pre_model(input logic [7:0] op, input longint unsigned d,
                                                input longint unsigned b);
    if (!op[4]) return b;
    if (op[6])  return (d + MOD18 - b) % MOD18;
    return (d + b) % MOD18;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    longint unsigned xv, zv, cv, sum;
    logic [7:0] op;
    int idx;

    set_rst(1'b1); set_ce(1'b1);
    A = 18'd5; B = 18'd6; D = 18'd3; BCIN = 18'd9; C = 48'h123; PCIN = 48'd1;
    CARRYIN = 1'b1; OPMODE = 8'h0D;
    tick(6);

    // Asynchronous clear in mid-cycle, inputs still nonzero.
    @(negedge CLK); set_rst(1'b0); #1;
    check("rst_BCOUT", BCOUT, 0); check("rst_M", M, 0); check("rst_P", P, 0);
    check("rst_PCOUT", PCOUT, 0); check("rst_CARRYOUT", CARRYOUT, 0);
    check("rst_CARRYOUTF", CARRYOUTF, 0);

    A = 18'd1; B = 18'd30; D = 18'd70; C = 48'd0; CARRYIN = 1'b0; OPMODE = 8'h11;
    #1 set_rst(1'b1);
    tick(4);
    check("preadd_BCOUT", BCOUT, 100); check("preadd_M", M, 100);
    check("preadd_P", P, 100); check("preadd_CO", CARRYOUT, 0);

    OPMODE = 8'h51; D = 18'd50; B = 18'd20;
    tick(4);
    check("presub_BCOUT", BCOUT, 30); check("presub_M", M, 30); check("presub_P", P, 30);

    OPMODE = 8'h11; D = 18'h3FFFF; B = 18'd2;
    tick(4);
    check("prewrap_BCOUT", BCOUT, 1); check("prewrap_P", P, 1);

    OPMODE = 8'h01; A = 18'd10; B = 18'd5;
    tick(4);
    check("mul_BCOUT", BCOUT, 5); check("mul_M", M, 50); check("mul_P", P, 50);

    OPMODE = 8'h0D; A = 18'd7; B = 18'd3; C = 48'd1; CARRYIN = 1'b1;
    tick(4);
    check("postadd_M", M, 21); check("postadd_P", P, 23); check("postadd_CO", CARRYOUT, 0);

    OPMODE = 8'h8D; A = 18'd1; B = 18'd11; C = 48'd14; CARRYIN = 1'b1;
    tick(4);
    check("postsub_M", M, 11); check("postsub_P", P, 2); check("postsub_CO", CARRYOUT, 0);

    B = 18'd1; C = 48'd0; CARRYIN = 1'b0;
    tick(4);
    check("borrow_P", P, MASK48); check("borrow_PCOUT", PCOUT, MASK48);
    check("borrow_CO", CARRYOUT, 1); check("borrow_COF", CARRYOUTF, 1);

    CEP = 1'b0; OPMODE = 8'h0D; A = 18'd5; B = 18'd5; C = 48'd7;
    tick(4);
    check("cep_hold_P", P, MASK48); check("cep_hold_CO", CARRYOUT, 1); check("cep_M", M, 25);
    CEP = 1'b1;
    tick(1);
    check("cep_resume_P", P, 32); check("cep_resume_CO", CARRYOUT, 0);

    // Clearing only the M stage: P keeps its value, then the zero flushes through.
    @(negedge CLK); RSTM = 1'b0; #1;
    check("rstm_M", M, 0); check("rstm_P", P, 32); check("rstm_BCOUT", BCOUT, 5);
    #2 RSTM = 1'b1;
    tick(1);
    check("rstm_flush_M", M, 25); check("rstm_flush_P", P, 7);
    tick(1);
    check("rstm_refill_P", P, 32);

    OPMODE = 8'h09; A = 18'd2; B = 18'd3;
    tick(3);
    check("acc_M", M, 6); check("acc_P3", P, 63);
    tick(1);
    check("acc_P4", P, 69);

    // Randomized phase from a clean pipeline; history before edge 0 is all zero.
    @(negedge CLK); set_rst(1'b0); #1;
    for (int i = 0; i < OFF; i++) begin
      a_h[i] = 0; b_h[i] = 0; d_h[i] = 0; c_h[i] = 0; pcin_h[i] = 0; ci_h[i] = 0; op_h[i] = '0;
      b1_m[i] = 0; m_m[i] = 0; p_m[i] = 0; co_m[i] = 0;
    end
    set_rst(1'b1);
    for (int k = 0; k < NRAND; k++) begin
      idx = k + OFF;
      a_h[idx]    = longint'($urandom) & (MOD18 - 1);
      b_h[idx]    = longint'($urandom) & (MOD18 - 1);
      d_h[idx]    = longint'($urandom) & (MOD18 - 1);
      c_h[idx]    = {$urandom, $urandom} & MASK48;
      pcin_h[idx] = {$urandom, $urandom} & MASK48;
      ci_h[idx]   = longint'($urandom_range(1, 0));
      op_h[idx]   = 8'($urandom);
      A = 18'(a_h[idx]); B = 18'(b_h[idx]); D = 18'(d_h[idx]); C = 48'(c_h[idx]);
      PCIN = 48'(pcin_h[idx]); CARRYIN = ci_h[idx][0]; OPMODE = op_h[idx];
      BCIN = 18'($urandom);
      tick(1);

      op = op_h[idx-1];
      b1_m[idx] = pre_model(op, d_h[idx-1], b_h[idx]);
      m_m[idx]  = a_h[idx-1] * b1_m[idx-1];
      case (op[1:0])
        2'd0: xv = 0;
        2'd1: xv = m_m[idx-1];
        2'd2: xv = p_m[idx-1];
        default: xv = ((d_h[idx-1] & 64'hFFF) << 36) | (a_h[idx-1] << 18) | b1_m[idx-1];
      endcase
      case (op[3:2])
        2'd0: zv = 0;
        2'd1: zv = pcin_h[idx];
        2'd2: zv = p_m[idx-1];
        default: zv = c_h[idx-1];
      endcase
      cv = ci_h[idx-1];
      if (op[7]) begin
        co_m[idx] = (xv + cv > zv) ? 1 : 0;
        p_m[idx]  = (zv - xv - cv) & MASK48;
      end else begin
        sum       = zv + xv + cv;
        co_m[idx] = sum >> 48;
        p_m[idx]  = sum & MASK48;
      end

      check("rnd_BCOUT", BCOUT, b1_m[idx]);
      check("rnd_M", M, m_m[idx]);
      check("rnd_P", P, p_m[idx]);
      check("rnd_PCOUT", PCOUT, p_m[idx]);
      check("rnd_CO", CARRYOUT, co_m[idx]);
      check("rnd_COF", CARRYOUTF, co_m[idx]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
